tdm_demux_1xn: RTL and testbench

Time-division demultiplexer: receives a 1-bit serial stream framed by a start-of-frame marker and distributes consecutive valid bits into NCH parallel, registered output channels. It is the receiving end of the board-level select/mux path. A single switch line carries NCH logical signals, which are fanned back out to LEDs. A frame commits atomically, so outputs never show a partially received frame.

---
 rtl/tdm_pkg.sv | 19 +
 rtl/tdm_demux_1xn_if.sv | 27 ++
 rtl/tdm_demux_1xn_slot_counter.sv | 34 +++
 rtl/tdm_demux_1xn.sv | 109 ++++++++++
 tb/tb_tdm_demux_1xn.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM select/mux path (receiver and matching transmitter).
package tdm_pkg;

    localparam int unsigned NCH_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    function automatic int unsigned sw_for(input int unsigned nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

    function automatic bit nch_ok(input int unsigned nch, input int unsigned sw);
        return (nch >= 1) && (nch <= 32) && (sw == sw_for(nch));
    endfunction

endpackage

// File: rtl/tdm_demux_1xn_if.sv
// Serial-in / parallel-out bundle between the TDM stream source and the demux.
interface tdm_demux_1xn_if
    import tdm_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEFAULT,
    parameter int unsigned SW  = sw_for(NCH)
) ();

    logic           din;
    logic           din_valid;
    logic           sof;
    logic [NCH-1:0] ch_out;
    logic           frame_done;
    logic           sync_err;
    logic [SW-1:0]  slot_idx;

    modport master (
        output din, din_valid, sof,
        input  ch_out, frame_done, sync_err, slot_idx
    );

    modport slave (
        input  din, din_valid, sof,
        output ch_out, frame_done, sync_err, slot_idx
    );

endinterface

// File: rtl/tdm_demux_1xn_slot_counter.sv
// Slot index counter: clear beats load-to-1 beats increment; wraps after NCH-1.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEFAULT,
    parameter int unsigned SW  = sw_for(NCH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          load1,
    input  logic          clr,
    output logic [SW-1:0] cnt,
    output logic          last_slot
);

    localparam logic [SW-1:0] LAST = SW'(NCH - 1);
    localparam logic [SW-1:0] ONE  = (NCH > 1) ? SW'(1) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= ONE;
        end else if (inc) begin
            cnt <= last_slot ? '0 : cnt + SW'(1);
        end
    end

    assign last_slot = (cnt == LAST);

endmodule

// File: rtl/tdm_demux_1xn.sv
// TDM demultiplexer: collects NCH serial slots into a shadow register and
// commits them to ch_out atomically once the frame is complete.
module tdm_demux_1xn
    import tdm_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEFAULT,
    parameter int unsigned SW  = sw_for(NCH)
) (
    input logic           clk,
    input logic           rst,
    tdm_demux_1xn_if.slave bus
);

    if (!nch_ok(NCH, SW)) begin : g_bad_cfg
        $error("tdm_demux_1xn: NCH must be 1..32 and SW must match it");
    end

    state_t         state, state_n;
    logic [NCH-1:0] shadow, shadow_n;
    logic [NCH-1:0] ch_q, ch_n;
    logic [NCH-1:0] commit_val;
    logic           fd_q, fd_n;
    logic           se_q, se_n;
    logic           cnt_inc, cnt_load1, cnt_clr;
    logic [SW-1:0]  slot;
    logic           last_slot;

    tdm_slot_counter #(
        .NCH (NCH),
        .SW  (SW)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .inc       (cnt_inc),
        .load1     (cnt_load1),
        .clr       (cnt_clr),
        .cnt       (slot),
        .last_slot (last_slot)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            shadow <= '0;
            ch_q   <= '0;
            fd_q   <= 1'b0;
            se_q   <= 1'b0;
        end else begin
            state  <= state_n;
            shadow <= shadow_n;
            ch_q   <= ch_n;
            fd_q   <= fd_n;
            se_q   <= se_n;
        end
    end

    always_comb begin
        state_n   = state;
        shadow_n  = shadow;
        ch_n      = ch_q;
        fd_n      = 1'b0;
        se_n      = 1'b0;
        cnt_inc   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_clr   = 1'b0;
        // Top bit replaced by the live beat; also covers NCH=1 without a negative slice.
        commit_val          = shadow;
        commit_val[NCH-1]   = bus.din;

        if (bus.din_valid) begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.sof) begin
                        shadow_n[0] = bus.din;
                        if (NCH == 1) begin
                            ch_n = commit_val;
                            fd_n = 1'b1;
                        end else begin
                            cnt_load1 = 1'b1;
                            state_n   = ST_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    if (bus.sof) begin
                        se_n        = 1'b1;
                        shadow_n[0] = bus.din;
                        cnt_load1   = 1'b1;
                    end else if (last_slot) begin
                        ch_n    = commit_val;
                        fd_n    = 1'b1;
                        cnt_clr = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        shadow_n[slot] = bus.din;
                        cnt_inc        = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign bus.ch_out     = ch_q;
    assign bus.frame_done = fd_q;
    assign bus.sync_err   = se_q;
    assign bus.slot_idx   = slot;

endmodule

// File: tb/tb_tdm_demux_1xn.sv
// Directed self-checking bench for tdm_demux_1xn (NCH=8 and NCH=1 instances).
module tb_tdm_demux_1xn;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    tdm_demux_1xn_if #(.NCH(8), .SW(3)) bus8 ();
    tdm_demux_1xn_if #(.NCH(1), .SW(1)) bus1 ();

    tdm_demux_1xn #(.NCH(8), .SW(3)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    tdm_demux_1xn #(.NCH(1), .SW(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs applied at a falling edge; outputs read at the next falling edge.
    task automatic drive8(input logic v, input logic s, input logic d);
        bus8.din_valid = v;
        bus8.sof       = s;
        bus8.din       = d;
        @(negedge clk);
    endtask

    task automatic drive1(input logic v, input logic s, input logic d);
        bus1.din_valid = v;
        bus1.sof       = s;
        bus1.din       = d;
        @(negedge clk);
    endtask

    task automatic frame8(input logic [7:0] v, input logic [7:0] prev, input logic serr0,
                          input int stall_a, input int stall_b);
        for (int k = 0; k < 8; k++) begin
            drive8(1'b1, (k == 0), v[k]);
            if (k == 0) chk("serr_first", {31'd0, bus8.sync_err}, {31'd0, serr0});
            else        chk("serr_mid", {31'd0, bus8.sync_err}, 32'd0);
            if (k < 7) begin
                chk("fd_mid", {31'd0, bus8.frame_done}, 32'd0);
                chk("ch_hold", {24'd0, bus8.ch_out}, {24'd0, prev});
                chk("slot_adv", {29'd0, bus8.slot_idx}, k + 1);
            end else begin
                chk("fd_last", {31'd0, bus8.frame_done}, 32'd1);
                chk("ch_commit", {24'd0, bus8.ch_out}, {24'd0, v});
                chk("slot_wrap", {29'd0, bus8.slot_idx}, 32'd0);
            end
            if (k == stall_a || k == stall_b) begin
                drive8(1'b0, 1'b1, ~v[k]);
                chk("stall_fd", {31'd0, bus8.frame_done}, 32'd0);
                chk("stall_serr", {31'd0, bus8.sync_err}, 32'd0);
                chk("stall_slot", {29'd0, bus8.slot_idx}, k + 1);
                chk("stall_ch", {24'd0, bus8.ch_out}, {24'd0, prev});
            end
        end
    endtask

    initial begin
        bus8.din_valid = 1'b0; bus8.sof = 1'b0; bus8.din = 1'b0;
        bus1.din_valid = 1'b0; bus1.sof = 1'b0; bus1.din = 1'b0;

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        chk("rst_ch", {24'd0, bus8.ch_out}, 32'd0);
        chk("rst_fd", {31'd0, bus8.frame_done}, 32'd0);
        chk("rst_serr", {31'd0, bus8.sync_err}, 32'd0);
        chk("rst_slot", {29'd0, bus8.slot_idx}, 32'd0);
        rst = 1'b1;

        // Idle beats without sof are ignored
        drive8(1'b1, 1'b0, 1'b1);
        chk("idle_ign_slot", {29'd0, bus8.slot_idx}, 32'd0);
        chk("idle_ign_ch", {24'd0, bus8.ch_out}, 32'd0);
        drive8(1'b0, 1'b0, 1'b0);

        // Clean frame 1,0,1,1,0,0,1,0 -> 8'h4D
        frame8(8'h4D, 8'h00, 1'b0, -1, -1);
        drive8(1'b0, 1'b0, 1'b0);
        chk("clean_fd_drop", {31'd0, bus8.frame_done}, 32'd0);
        chk("clean_ch_keep", {24'd0, bus8.ch_out}, 32'h4D);

        // Same frame with stalls after slots 2 and 5
        frame8(8'h4D, 8'h4D, 1'b0, 2, 5);
        drive8(1'b0, 1'b0, 1'b0);
        chk("stall_fd_drop", {31'd0, bus8.frame_done}, 32'd0);

        // Resync: 3-beat partial frame, then sof with 8'hA5
        drive8(1'b1, 1'b1, 1'b1);
        drive8(1'b1, 1'b0, 1'b1);
        drive8(1'b1, 1'b0, 1'b1);
        chk("partial_slot", {29'd0, bus8.slot_idx}, 32'd3);
        chk("partial_ch", {24'd0, bus8.ch_out}, 32'h4D);
        frame8(8'hA5, 8'h4D, 1'b1, -1, -1);

        // Back-to-back frames with no idle cycle between them
        frame8(8'h3C, 8'hA5, 1'b0, -1, -1);
        frame8(8'hC3, 8'h3C, 1'b0, -1, -1);

        // Third frame reset at slot 4
        drive8(1'b1, 1'b1, 1'b1);
        drive8(1'b1, 1'b0, 1'b0);
        drive8(1'b1, 1'b0, 1'b1);
        drive8(1'b1, 1'b0, 1'b1);
        chk("pre_rst_slot", {29'd0, bus8.slot_idx}, 32'd4);
        bus8.din_valid = 1'b1; bus8.sof = 1'b0; bus8.din = 1'b1;
        rst = 1'b0;
        #1;
        chk("midrst_ch", {24'd0, bus8.ch_out}, 32'd0);
        chk("midrst_slot", {29'd0, bus8.slot_idx}, 32'd0);
        chk("midrst_fd", {31'd0, bus8.frame_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive8(1'b1, 1'b0, 1'b1);
            chk("post_rst_ign_slot", {29'd0, bus8.slot_idx}, 32'd0);
            chk("post_rst_ign_fd", {31'd0, bus8.frame_done}, 32'd0);
        end
        chk("post_rst_ign_ch", {24'd0, bus8.ch_out}, 32'd0);
        frame8(8'h5A, 8'h00, 1'b0, -1, -1);
        drive8(1'b0, 1'b0, 1'b0);

        // NCH=1 instance
        chk("n1_rst_ch", {31'd0, bus1.ch_out}, 32'd0);
        drive1(1'b1, 1'b1, 1'b1);
        chk("n1_ch", {31'd0, bus1.ch_out}, 32'd1);
        chk("n1_fd", {31'd0, bus1.frame_done}, 32'd1);
        chk("n1_serr", {31'd0, bus1.sync_err}, 32'd0);
        chk("n1_slot", {31'd0, bus1.slot_idx}, 32'd0);
        drive1(1'b1, 1'b1, 1'b0);
        chk("n1_b2b_ch", {31'd0, bus1.ch_out}, 32'd0);
        chk("n1_b2b_fd", {31'd0, bus1.frame_done}, 32'd1);
        chk("n1_b2b_serr", {31'd0, bus1.sync_err}, 32'd0);
        drive1(1'b1, 1'b0, 1'b1);
        chk("n1_nosof_ch", {31'd0, bus1.ch_out}, 32'd0);
        chk("n1_nosof_fd", {31'd0, bus1.frame_done}, 32'd0);
        drive1(1'b0, 1'b1, 1'b1);
        chk("n1_stall_ch", {31'd0, bus1.ch_out}, 32'd0);
        chk("n1_stall_fd", {31'd0, bus1.frame_done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
